jk_sync_counter_ctrl: RTL
=========================

JK_SYNC_COUNTER_CTRL -- requirements
Module: jk_sync_counter_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, counter width in bits (legal 2..8).
REQ-002 Port: clk  input  1  rising-edge clock; all state changes on posedge clk only.
REQ-003 Port: sync_reset_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 Port: en  input  1  count enable; 1 = advance one step this edge.
REQ-005 Port: up  input  1  direction; 1 = up, 0 = down; sampled only when counting.
REQ-006 Port: load  input  1  parallel load strobe.
REQ-007 Port: d  input  WIDTH  parallel load value.
REQ-008 Port: mod_max  input  WIDTH  highest count value; count range 0..mod_max.
REQ-009 Port: Q  output  WIDTH  current count, taken directly from the JKff stage outputs.
REQ-010 Port: Qnot  output  WIDTH  bitwise complement of Q, taken from the JKff Qnot outputs.
REQ-011 Port: tc  output  1  terminal-count flag, combinational.
REQ-012 Port: wrap_cnt  output  8  registered count of wrap events, modulo 256.

Function
REQ-013 State SHALL be held in WIDTH instances of JKff, one per bit; this block generates the J/K excitation for each stage.
REQ-014 Each JKff sync_reset SHALL be driven by ~sync_reset_n.
REQ-015 Load excitation: J[i] = d[i], K[i] = ~d[i].
REQ-016 Count excitation: J[i] = K[i] = T[i], where T = Q XOR next.
REQ-017 Hold excitation: J = K = 0 for all bits.
REQ-018 Priority per edge: reset > load > en > hold.
REQ-019 Up count: next = 0 if Q >= mod_max, otherwise Q+1.
REQ-020 Down count: next = mod_max if Q == 0, otherwise Q-1.
REQ-021 Load of d > mod_max SHALL be accepted unchanged; the next up step then wraps to 0, and down steps decrement normally.
REQ-022 mod_max == 0: the counter SHALL stay at 0 while counting in either direction, and every enabled edge is a wrap.
REQ-023 tc = en & ~load & ((up & Q >= mod_max) | (~up & Q == 0)).
REQ-024 A wrap event is an edge on which tc = 1 and reset is inactive; wrap_cnt SHALL increment by 1 on that edge and roll over 255 -> 0.
REQ-025 Load SHALL NOT change wrap_cnt.
REQ-026 Latency: Q SHALL reflect load or count exactly one edge after the qualifying inputs are sampled.
REQ-027 Changing mod_max mid-count SHALL take effect on the next edge with no additional state.
REQ-028 Changing up mid-count SHALL reverse direction on the next edge with no skipped or repeated value.
REQ-029 Simultaneous load and en: load wins, no count occurs, and tc = 0.

Reset
REQ-030 While sync_reset_n = 0 at a rising edge: Q = 0, Qnot = all ones, and wrap_cnt = 0 after that edge.
REQ-031 Reset SHALL override load and en.
REQ-032 Between edges, reset assertion SHALL have no effect on outputs.
REQ-033 tc SHALL be evaluated combinationally from current Q and inputs, also during reset.
REQ-034 Reset asserted mid-count SHALL abandon the count with no partial update.

Verification
REQ-035 Up wrap: reset; mod_max=9, up=1, en=1 for 12 edges -> Q = 0..9,0,1; tc=1 only at Q=9; wrap_cnt=1.
REQ-036 Down wrap: load d=2, then mod_max=5, up=0, en=1 for 4 edges -> Q = 2,1,0,5,4; tc=1 at Q=0; wrap_cnt=1.
REQ-037 Load priority: Q=3, load=1, en=1, d=12, mod_max=9 -> Q=12, tc=0. Then up count for 1 edge -> Q=0, wrap_cnt +1.
REQ-038 Reset mid-operation: Q=7, wrap_cnt=4, sync_reset_n=0 with load=1, en=1 -> Q=0, Qnot=4'hF, wrap_cnt=0. Pulse reset low between edges -> no change.
REQ-039 Wrap rollover: mod_max=0, en=1 for 257 edges -> Q stays 0, wrap_cnt = 1.
REQ-040 Direction flip: mod_max=15, Q=14, up=1 then up=0 on the next edge -> Q = 15,14; no extra wrap.

Source files
------------

// File: rtl/jk_sync_counter_ctrl.sv
// ============================================================================
// Module   : jk_sync_counter_ctrl (with helper jk_ff)
// Brief    : Modulo up/down counter built from JK flip-flop stages.
//            The controller supplies the J/K excitation for every stage and
//            keeps a wrap-event counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jk_ff (
    input  logic clk,
    input  logic sync_reset,
    input  logic J,
    input  logic K,
    output logic Q,
    output logic Qnot
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        case ({J, K})
            2'b00:   q_d = q_q;
            2'b01:   q_d = 1'b0;
            2'b10:   q_d = 1'b1;
            default: q_d = ~q_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q    = q_q;
    assign Qnot = ~q_q;

endmodule

module jk_sync_counter_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             sync_reset_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] mod_max,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qnot,
    output logic             tc,
    output logic [7:0]       wrap_cnt
);

    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_zero = '0;

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_qnot;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_toggle;
    logic             w_at_top;
    logic             w_at_zero;
    logic             w_count;
    logic             w_tc;
    logic [7:0]       wrap_cnt_q;
    logic [7:0]       wrap_cnt_d;

    // One flip-flop per counter bit; reset lives inside each stage.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_stage
            jk_ff u_jk_ff (
                .clk        (clk),
                .sync_reset (~sync_reset_n),
                .J          (w_j[gi]),
                .K          (w_k[gi]),
                .Q          (w_q[gi]),
                .Qnot       (w_qnot[gi])
            );
        end
    endgenerate

    // ">=" rather than "==" so a value loaded above mod_max still wraps up.
    assign w_at_top  = (w_q >= mod_max);
    assign w_at_zero = (w_q == c_zero);
    assign w_count   = en & ~load;

    always_comb begin
        w_next = w_q;
        if (up) begin
            w_next = w_at_top ? c_zero : (w_q + c_one);
        end else begin
            w_next = w_at_zero ? mod_max : (w_q - c_one);
        end
    end

    assign w_toggle = w_q ^ w_next;

    always_comb begin
        w_j = c_zero;
        w_k = c_zero;
        if (load) begin
            w_j = d;
            w_k = ~d;
        end else if (en) begin
            w_j = w_toggle;
            w_k = w_toggle;
        end
    end

    assign w_tc = w_count & (up ? w_at_top : w_at_zero);

    always_comb begin
        wrap_cnt_d = wrap_cnt_q;
        if (w_tc) begin
            wrap_cnt_d = wrap_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            wrap_cnt_q <= 8'd0;
        end else begin
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign Q        = w_q;
    assign Qnot     = w_qnot;
    assign tc       = w_tc;
    assign wrap_cnt = wrap_cnt_q;

endmodule

`default_nettype wire
